// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA text pipeline.
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Screen geometry, text grid dimensions and pixel colour type.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

   localparam int H_VISIBLE  = 640;
   localparam int V_VISIBLE  = 480;
   localparam int GLYPH_W    = 8;
   localparam int GLYPH_H    = 16;
   localparam int TEXT_COLS  = 80;
   localparam int TEXT_ROWS  = 30;
   localparam int TEXT_CELLS = TEXT_COLS * TEXT_ROWS;

   typedef logic [2:0] rgb3;

   // row*80 built from two shifts so no multiplier is needed
   function automatic logic [11:0] cell_index(input logic [4:0] row, input logic [6:0] col);
      logic [11:0] r;
      r = {7'd0, row};
      return (r << 6) + (r << 4) + {5'd0, col};
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_text_renderer_if.sv
// Bundle of sync-generator, text-write, cursor and VGA pin signals.
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_text_renderer_if
// Purpose  : Groups renderer inputs and VGA outputs; master drives, slave renders.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_text_renderer_if;
   import vga_pkg::*;

   logic [9:0]  counter_x;
   logic [9:0]  counter_y;
   logic        display_in;
   logic        h_sync_in;
   logic        v_sync_in;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic        cursor_en;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   rgb3         vga_rgb;
   logic        vga_h_sync;
   logic        vga_v_sync;

   modport master (
      output counter_x, counter_y, display_in, h_sync_in, v_sync_in,
      output wr_en, wr_addr, wr_data, cursor_en, cursor_col, cursor_row,
      input  vga_rgb, vga_h_sync, vga_v_sync
   );

   modport slave (
      input  counter_x, counter_y, display_in, h_sync_in, v_sync_in,
      input  wr_en, wr_addr, wr_data, cursor_en, cursor_col, cursor_row,
      output vga_rgb, vga_h_sync, vga_v_sync
   );

endinterface
`default_nettype wire

// File: rtl/vga_font_rom.sv
// 2048x8 glyph ROM, address {code[6:0], line[3:0]}, one-clock registered read.
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_font_rom
// Purpose  : Synchronous 8x16 font ROM; undefined glyphs read as blank.
// Revision : 1.0 - initial release
// ============================================================================
module vga_font_rom (
   input  logic        clk,
   input  logic [10:0] addr_i,
   output logic [7:0]  data_o
);

   logic [7:0] data_q;

   // MSB is the leftmost pixel of each glyph line
   function automatic logic [7:0] glyph_line(input logic [6:0] code, input logic [3:0] line);
      logic [7:0] v;
      v = 8'h00;
      case (code)
         7'h41: begin
            case (line)
               4'd5:                v = 8'h18;
               4'd6:                v = 8'h3C;
               4'd7, 4'd8:          v = 8'h66;
               4'd9:                v = 8'h7E;
               4'd10, 4'd11, 4'd12: v = 8'h66;
               default:             v = 8'h00;
            endcase
         end
         7'h48: begin
            if (line >= 4'd3 && line <= 4'd12)
               v = (line == 4'd7) ? 8'h7E : 8'h66;
         end
         7'h7F:   v = 8'hFF;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   always_ff @(posedge clk) begin
      data_q <= glyph_line(addr_i[10:4], addr_i[3:0]);
   end

   assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/vga_text_renderer.sv
// Four-stage text renderer: cell address, text RAM, font ROM, pixel select.
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_text_renderer
// Purpose  : 80x30 text screen with inverse attribute and blinking cursor.
// Revision : 1.0 - initial release
// ============================================================================
module vga_text_renderer
   import vga_pkg::*;
#(
   parameter int  COLS      = TEXT_COLS,
   parameter int  ROWS      = TEXT_ROWS,
   parameter rgb3 FG_COLOR  = 3'b111,
   parameter rgb3 BG_COLOR  = 3'b000,
   parameter int  BLINK_BIT = 5
)(
   input  logic               clk,
   input  logic               rst,
   vga_text_renderer_if.slave vga
);

   localparam logic [6:0]  NCOLS  = 7'(COLS);
   localparam logic [4:0]  NROWS  = 5'(ROWS);
   localparam logic [11:0] NCELLS = 12'(COLS * ROWS);

   logic [7:0]  text_ram_q [0:COLS*ROWS-1];

   logic [11:0] cell_q1;
   logic [2:0]  xf_q1, xf_q2, xf_q3;
   logic [3:0]  yf_q1, yf_q2;
   logic        disp_q1, disp_q2, disp_q3;
   logic        hs_q1, hs_q2, hs_q3, hs_q;
   logic        vs_q1, vs_q2, vs_q3, vs_q;
   logic        hit_q1, hit_q2, hit_q3;
   logic        inv_q3;
   logic [7:0]  code_q2;
   logic [7:0]  font_q3;
   rgb3         rgb_q;
   logic        vs_prev_q;
   logic [5:0]  frame_cnt_q;

   logic [6:0]  col_d;
   logic [4:0]  row_d;
   logic [11:0] cell_d;
   logic        hit_d;
   logic        pix_bit_d;
   logic        on_d;
   rgb3         rgb_d;
   logic        unused_y_msb;

   assign unused_y_msb = vga.counter_y[9];

   always_comb begin
      col_d  = vga.counter_x[9:3];
      row_d  = vga.counter_y[8:4];
      cell_d = vga.display_in ? cell_index(row_d, col_d) : 12'd0;
      // an off-screen cursor position must never match a visible cell
      hit_d  = vga.cursor_en && vga.display_in
               && (vga.cursor_col < NCOLS) && (vga.cursor_row < NROWS)
               && (col_d == vga.cursor_col) && (row_d == vga.cursor_row)
               && frame_cnt_q[BLINK_BIT];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cell_q1 <= 12'd0;
         xf_q1   <= 3'd0;
         yf_q1   <= 4'd0;
         disp_q1 <= 1'b0;
         hs_q1   <= 1'b1;
         vs_q1   <= 1'b1;
         hit_q1  <= 1'b0;
      end else begin
         cell_q1 <= cell_d;
         xf_q1   <= vga.counter_x[2:0];
         yf_q1   <= vga.counter_y[3:0];
         disp_q1 <= vga.display_in;
         hs_q1   <= vga.h_sync_in;
         vs_q1   <= vga.v_sync_in;
         hit_q1  <= hit_d;
      end
   end

   // Block-RAM style: no reset, read-before-write on address collision
   always_ff @(posedge clk) begin
      if (vga.wr_en && (vga.wr_addr < NCELLS))
         text_ram_q[vga.wr_addr] <= vga.wr_data;
      code_q2 <= text_ram_q[cell_q1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xf_q2   <= 3'd0;
         yf_q2   <= 4'd0;
         disp_q2 <= 1'b0;
         hs_q2   <= 1'b1;
         vs_q2   <= 1'b1;
         hit_q2  <= 1'b0;
      end else begin
         xf_q2   <= xf_q1;
         yf_q2   <= yf_q1;
         disp_q2 <= disp_q1;
         hs_q2   <= hs_q1;
         vs_q2   <= vs_q1;
         hit_q2  <= hit_q1;
      end
   end

   vga_font_rom u_font_rom (
      .clk    (clk),
      .addr_i ({code_q2[6:0], yf_q2}),
      .data_o (font_q3)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xf_q3   <= 3'd0;
         inv_q3  <= 1'b0;
         disp_q3 <= 1'b0;
         hs_q3   <= 1'b1;
         vs_q3   <= 1'b1;
         hit_q3  <= 1'b0;
      end else begin
         xf_q3   <= xf_q2;
         inv_q3  <= code_q2[7];
         disp_q3 <= disp_q2;
         hs_q3   <= hs_q2;
         vs_q3   <= vs_q2;
         hit_q3  <= hit_q2;
      end
   end

   always_comb begin
      pix_bit_d = font_q3[3'd7 - xf_q3];
      on_d      = pix_bit_d ^ inv_q3 ^ hit_q3;
      rgb_d     = disp_q3 ? (on_d ? FG_COLOR : BG_COLOR) : 3'b000;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rgb_q <= 3'b000;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
      end else begin
         rgb_q <= rgb_d;
         hs_q  <= hs_q3;
         vs_q  <= vs_q3;
      end
   end

   // Frame counter advances at the leading (falling) edge of vsync
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vs_prev_q   <= 1'b1;
         frame_cnt_q <= 6'd0;
      end else begin
         vs_prev_q <= vga.v_sync_in;
         if (vs_prev_q && !vga.v_sync_in)
            frame_cnt_q <= frame_cnt_q + 6'd1;
      end
   end

   assign vga.vga_rgb    = rgb_q;
   assign vga.vga_h_sync = hs_q;
   assign vga.vga_v_sync = vs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_text_renderer.sv
// Directed self-checking bench for vga_text_renderer.
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_text_renderer
// Purpose  : Directed vectors with hand-computed expected pixels and syncs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_text_renderer;
   import vga_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   vga_text_renderer_if vga ();

   vga_text_renderer #(
      .COLS      (80),
      .ROWS      (30),
      .FG_COLOR  (3'b111),
      .BG_COLOR  (3'b000),
      .BLINK_BIT (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .vga (vga)
   );

   always #20 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [11:0] addr, input logic [7:0] data);
      vga.wr_en   = 1'b1;
      vga.wr_addr = addr;
      vga.wr_data = data;
      @(negedge clk);
      vga.wr_en   = 1'b0;
   endtask

   task automatic pixd(input logic [9:0] x, input logic [9:0] y, input logic d,
                       input logic [2:0] exp, input string tag);
      vga.counter_x  = x;
      vga.counter_y  = y;
      vga.display_in = d;
      repeat (4) @(negedge clk);
      chk(tag, {5'd0, vga.vga_rgb}, {5'd0, exp});
   endtask

   task automatic pix(input logic [9:0] x, input logic [9:0] y,
                      input logic [2:0] exp, input string tag);
      pixd(x, y, (x < 10'd640) && (y < 10'd480), exp, tag);
   endtask

   task automatic vpulse(input int n);
      for (int i = 0; i < n; i++) begin
         vga.v_sync_in = 1'b0;
         @(negedge clk);
         vga.v_sync_in = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [7:0] a_row5;
      a_row5 = 8'h18;

      vga.counter_x  = '0;
      vga.counter_y  = '0;
      vga.display_in = 1'b0;
      vga.h_sync_in  = 1'b1;
      vga.v_sync_in  = 1'b1;
      vga.wr_en      = 1'b0;
      vga.wr_addr    = '0;
      vga.wr_data    = '0;
      vga.cursor_en  = 1'b0;
      vga.cursor_col = '0;
      vga.cursor_row = '0;
      rst            = 1'b0;

      #30;
      chk("reset_rgb", {5'd0, vga.vga_rgb}, 8'h00);
      chk("reset_hs", {7'd0, vga.vga_h_sync}, 8'h01);
      chk("reset_vs", {7'd0, vga.vga_v_sync}, 8'h01);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 2400; i++) wr(12'(i), 8'h00);
      pix(10'd100, 10'd100, 3'b000, "bg_visible");
      pix(10'd700, 10'd100, 3'b000, "blank_outside");

      // hsync delay: exactly four clocks
      vga.counter_x = 10'd656;
      vga.h_sync_in = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("hs_delay_%0d", k), {7'd0, vga.vga_h_sync}, (k < 4) ? 8'h01 : 8'h00);
      end
      vga.h_sync_in = 1'b1;
      repeat (4) @(negedge clk);

      wr(12'd81, 8'h41);
      pix(10'd10, 10'd21, 3'b000, "align_pre");
      vga.counter_x = 10'd11;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("rgb_delay_%0d", k), {5'd0, vga.vga_rgb}, (k < 4) ? 8'h00 : 8'h07);
      end

      for (int x = 8; x < 16; x++)
         pix(10'(x), 10'd21, a_row5[7 - (x - 8)] ? 3'b111 : 3'b000, $sformatf("glyph_x%0d", x));
      pix(10'd8, 10'd25, 3'b000, "glyph_row9_x8");
      pix(10'd9, 10'd25, 3'b111, "glyph_row9_x9");

      wr(12'd81, 8'hC1);
      for (int x = 8; x < 16; x++)
         pix(10'(x), 10'd21, a_row5[7 - (x - 8)] ? 3'b000 : 3'b111, $sformatf("inverse_x%0d", x));

      wr(12'd0, 8'h80);
      pixd(10'd3, 10'd3, 1'b1, 3'b111, "inv_blank_visible");
      pixd(10'd3, 10'd3, 1'b0, 3'b000, "blanking_forced");
      wr(12'd0, 8'h00);

      wr(12'd2399, 8'h41);
      pix(10'd635, 10'd469, 3'b111, "last_cell_on3");
      pix(10'd636, 10'd469, 3'b111, "last_cell_on4");
      pix(10'd632, 10'd469, 3'b000, "last_cell_off0");
      wr(12'd2400, 8'h7F);
      pix(10'd3, 10'd5, 3'b000, "oob_write_cell0");
      pix(10'd635, 10'd469, 3'b111, "oob_write_last");

      // read and write of cell 81 meet on the same clock edge
      wr(12'd81, 8'h41);
      @(negedge clk);
      vga.counter_x  = 10'd11;
      vga.counter_y  = 10'd21;
      vga.display_in = 1'b1;
      @(negedge clk);
      vga.counter_x  = 10'd700;
      vga.display_in = 1'b0;
      vga.wr_en      = 1'b1;
      vga.wr_addr    = 12'd81;
      vga.wr_data    = 8'h00;
      @(negedge clk);
      vga.wr_en      = 1'b0;
      repeat (2) @(negedge clk);
      chk("rdw_old", {5'd0, vga.vga_rgb}, 8'h07);
      pix(10'd11, 10'd21, 3'b000, "rdw_new");

      vga.v_sync_in = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("vs_delay_%0d", k), {7'd0, vga.vga_v_sync}, (k < 4) ? 8'h01 : 8'h00);
      end
      vga.v_sync_in = 1'b1;
      repeat (4) @(negedge clk);

      // one vsync edge so far: frame 1
      vga.cursor_en  = 1'b1;
      vga.cursor_col = 7'd0;
      vga.cursor_row = 5'd0;
      pix(10'd0, 10'd0, 3'b000, "cur_f1");
      vpulse(30);
      pix(10'd7, 10'd15, 3'b000, "cur_f31");
      vpulse(1);
      pix(10'd0, 10'd0, 3'b111, "cur_f32_tl");
      pix(10'd7, 10'd15, 3'b111, "cur_f32_br");
      pix(10'd3, 10'd8, 3'b111, "cur_f32_mid");
      pix(10'd8, 10'd0, 3'b000, "cur_next_col");
      pix(10'd0, 10'd16, 3'b000, "cur_next_row");
      vga.cursor_col = 7'd5;
      vga.cursor_row = 5'd2;
      pix(10'd40, 10'd32, 3'b111, "cur_moved_on");
      pix(10'd0, 10'd0, 3'b000, "cur_moved_off");
      vga.cursor_col = 7'd80;
      vga.cursor_row = 5'd0;
      pix(10'd0, 10'd0, 3'b000, "cur_col80_c0");
      pix(10'd632, 10'd0, 3'b000, "cur_col80_c79");
      vga.cursor_col = 7'd0;
      vpulse(32);
      pix(10'd0, 10'd0, 3'b000, "cur_f64_wrap");
      vpulse(32);
      pix(10'd0, 10'd0, 3'b111, "cur_f96");
      vga.cursor_en = 1'b0;

      wr(12'd81, 8'h41);
      vga.h_sync_in = 1'b0;
      pix(10'd11, 10'd21, 3'b111, "pre_reset_rgb");
      chk("pre_reset_hs", {7'd0, vga.vga_h_sync}, 8'h00);
      #5 rst = 1'b0;
      #1;
      chk("async_reset_rgb", {5'd0, vga.vga_rgb}, 8'h00);
      chk("async_reset_hs", {7'd0, vga.vga_h_sync}, 8'h01);
      chk("async_reset_vs", {7'd0, vga.vga_v_sync}, 8'h01);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("resume_rgb_%0d", k), {5'd0, vga.vga_rgb}, (k < 4) ? 8'h00 : 8'h07);
         chk($sformatf("resume_hs_%0d", k), {7'd0, vga.vga_h_sync}, (k < 4) ? 8'h01 : 8'h00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
